// File: rtl/range_detuner.sv
// range_detuner: converts a value tuned in [min,max] back to the raw range 0..2^power.
//   piece   = (1 << power) / (max - min)   (0 when max == min)
//   raw_num = (tuned - min) * piece        (low WIDTH bits)
// The divide is a one-bit-per-cycle restoring divider and the multiply a one-bit-per-cycle
// shift-add. All arithmetic is unsigned and modulo 2^WIDTH.
//
// Optional feature macro: DETUNER_RANGE_CHECK_EN
//   defined   - tuned outside [min,max] completes right after the operand cycle with
//               raw_num=0 and err=1
//   undefined - no check, err is tied to 0, subtraction wraps
//
// Ports:
//   clk      in   clock, rising-edge active
//   reset    in   synchronous active-high reset
//   start    in   conversion request, sampled only in IDLE
//   power    in   [4:0] exponent of the raw range
//   tuned    in   [WIDTH-1:0] value to convert
//   min      in   [WIDTH-1:0] lower bound of the tuned interval
//   max      in   [WIDTH-1:0] upper bound of the tuned interval
//   busy     out  high while the divider or multiplier is iterating
//   done     out  one-cycle pulse when raw_num/err are updated
//   raw_num  out  [WIDTH-1:0] converted value, held until the next done
//   err      out  out-of-range flag
module range_detuner #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       power,
   input  logic [WIDTH-1:0] tuned,
   input  logic [WIDTH-1:0] min,
   input  logic [WIDTH-1:0] max,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] raw_num,
   output logic             err
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StDiv, StMul, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [4:0]        power_q, power_d;
   logic [WIDTH-1:0]  tuned_q, tuned_d;
   logic [WIDTH-1:0]  min_q, min_d;
   logic [WIDTH-1:0]  max_q, max_d;
   logic [WIDTH-1:0]  rem_q, rem_d;     // divider partial remainder
   logic [WIDTH-1:0]  quo_q, quo_d;     // dividend/quotient, then multiplier
   logic [WIDTH-1:0]  dvs_q, dvs_d;     // divisor (max - min)
   logic [WIDTH-1:0]  ofs_q, ofs_d;     // tuned - min, then shifted multiplicand
   logic [WIDTH-1:0]  acc_q, acc_d;     // product accumulator
   logic [WIDTH-1:0]  raw_q, raw_d;

   logic [WIDTH-1:0]  pow;
   logic [WIDTH-1:0]  rem_sh;
   logic              rem_ge;
   logic [WIDTH-1:0]  div_rem;
   logic [WIDTH-1:0]  div_quo;
   logic [WIDTH-1:0]  mul_acc;

   // Shift amounts >= WIDTH shift the one out, giving pow = 0.
   assign pow = One << power_q;

   // The shifted remainder is WIDTH+1 bits wide; its top bit is the old remainder MSB and
   // forces a subtract, whose WIDTH-bit modular result is exact because it is < divisor.
   assign rem_sh  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign rem_ge  = rem_q[WIDTH-1] || (rem_sh >= dvs_q);
   assign div_rem = rem_ge ? (rem_sh - dvs_q) : rem_sh;
   assign div_quo = {quo_q[WIDTH-2:0], rem_ge};

   assign mul_acc = acc_q + (quo_q[0] ? ofs_q : '0);

`ifdef DETUNER_RANGE_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      power_d = power_q;
      tuned_d = tuned_q;
      min_d   = min_q;
      max_d   = max_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      ofs_d   = ofs_q;
      acc_d   = acc_q;
      raw_d   = raw_q;
`ifdef DETUNER_RANGE_CHECK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               power_d = power;
               tuned_d = tuned;
               min_d   = min;
               max_d   = max;
               cnt_d   = '0;
               state_d = StDiv;
            end
         end
         StDiv: begin
            if (cnt_q == '0) begin
               // Operand cycle: form dividend, divisor and offset from the captured inputs.
               quo_d = pow;
               rem_d = '0;
               dvs_d = max_q - min_q;
               ofs_d = tuned_q - min_q;
               cnt_d = cnt_q + CntW'(1);
`ifdef DETUNER_RANGE_CHECK_EN
               if ((tuned_q < min_q) || (tuned_q > max_q)) begin
                  state_d = StDone;
                  cnt_d   = '0;
                  raw_d   = '0;
                  err_d   = 1'b1;
               end
`endif
            end else begin
               rem_d = div_rem;
               quo_d = div_quo;
               if (cnt_q == CntW'(WIDTH)) begin
                  // Division by zero yields all ones; the defined result is piece = 0.
                  if (dvs_q == '0) quo_d = '0;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = StMul;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StMul: begin
            acc_d = mul_acc;
            ofs_d = ofs_q << 1;
            quo_d = quo_q >> 1;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               raw_d   = mul_acc;
`ifdef DETUNER_RANGE_CHECK_EN
               err_d   = 1'b0;
`endif
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         power_q <= '0;
         tuned_q <= '0;
         min_q   <= '0;
         max_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         ofs_q   <= '0;
         acc_q   <= '0;
         raw_q   <= '0;
`ifdef DETUNER_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         power_q <= power_d;
         tuned_q <= tuned_d;
         min_q   <= min_d;
         max_q   <= max_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         ofs_q   <= ofs_d;
         acc_q   <= acc_d;
         raw_q   <= raw_d;
`ifdef DETUNER_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // The operand cycle is not counted as busy; only the divide and multiply iterations are.
   assign busy    = (state_q == StMul) || ((state_q == StDiv) && (cnt_q != '0));
   assign done    = (state_q == StDone);
   assign raw_num = raw_q;

`ifdef DETUNER_RANGE_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
